// File: rtl/calculate_median_9_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calculate_median_9_pkg
// Purpose  : Shared constants for the 3x3 median datapath. DEFAULT_DATA_WIDTH
//            is the sample width used by default; LATENCY is the number of
//            clock edges from window capture to the median register, which
//            the filter top uses to delay its valid/sync strobes.
// Revision : 1.0 - initial release
// ============================================================================
package calculate_median_9_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int LATENCY            = 3;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

endpackage : calculate_median_9_pkg
`default_nettype wire

// File: rtl/calculate_median_9_sort3.sv
`default_nettype none
// ============================================================================
// Module   : calculate_median_9_sort3
// Purpose  : Combinational ascending sorter for three unsigned samples, built
//            from three compare-exchange cells.
// Ports    : i_a, i_b, i_c   samples to sort (any order)
//            o_lo, o_mid, o_hi  sorted result, o_lo <= o_mid <= o_hi
// Revision : 1.0 - initial release
// ============================================================================
module calculate_median_9_sort3 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_c,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic [DATA_WIDTH-1:0] o_mid,
    output logic [DATA_WIDTH-1:0] o_hi
);

    logic [DATA_WIDTH-1:0] w_ab_min;
    logic [DATA_WIDTH-1:0] w_ab_max;
    logic [DATA_WIDTH-1:0] w_bc_min;

    // Cell 1: order a and b.
    assign w_ab_min = (i_a < i_b) ? i_a : i_b;
    assign w_ab_max = (i_a < i_b) ? i_b : i_a;

    // Cell 2: larger of (a,b) against c yields the overall maximum.
    assign w_bc_min = (w_ab_max < i_c) ? w_ab_max : i_c;
    assign o_hi     = (w_ab_max < i_c) ? i_c : w_ab_max;

    // Cell 3: the two remaining values give minimum and middle.
    assign o_lo  = (w_ab_min < w_bc_min) ? w_ab_min : w_bc_min;
    assign o_mid = (w_ab_min < w_bc_min) ? w_bc_min : w_ab_min;

endmodule : calculate_median_9_sort3
`default_nettype wire

// File: rtl/calculate_median_9.sv
`default_nettype none
// ============================================================================
// Module   : calculate_median_9
// Purpose  : Three-stage pipelined exact median of a 3x3 window of unsigned
//            samples. One window accepted and one median produced per clock.
//              stage 1: sort each row -> (lo, mid, hi) per row
//              stage 2: a = max(lo's), b = median(mid's), c = min(hi's)
//              stage 3: median = median(a, b, c)
// Ports    : clk      rising-edge clock
//            rst      synchronous active-high reset, clears all stages
//            p0..p8   window samples, row-major (p0-p2 row 0 ... p6-p8 row 2)
//            median   registered median of the window
// Revision : 1.0 - initial release
// ============================================================================
module calculate_median_9
    import calculate_median_9_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p0,
    input  logic [DATA_WIDTH-1:0] p1,
    input  logic [DATA_WIDTH-1:0] p2,
    input  logic [DATA_WIDTH-1:0] p3,
    input  logic [DATA_WIDTH-1:0] p4,
    input  logic [DATA_WIDTH-1:0] p5,
    input  logic [DATA_WIDTH-1:0] p6,
    input  logic [DATA_WIDTH-1:0] p7,
    input  logic [DATA_WIDTH-1:0] p8,
    output logic [DATA_WIDTH-1:0] median
);

    // ------------------------------------------------------------------
    // Stage 1: per-row sort
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_row_in  [3][3];
    logic [DATA_WIDTH-1:0] w_row_lo  [3];
    logic [DATA_WIDTH-1:0] w_row_mid [3];
    logic [DATA_WIDTH-1:0] w_row_hi  [3];
    logic [DATA_WIDTH-1:0] r_row_lo  [3];
    logic [DATA_WIDTH-1:0] r_row_mid [3];
    logic [DATA_WIDTH-1:0] r_row_hi  [3];

    assign w_row_in[0][0] = p0;
    assign w_row_in[0][1] = p1;
    assign w_row_in[0][2] = p2;
    assign w_row_in[1][0] = p3;
    assign w_row_in[1][1] = p4;
    assign w_row_in[1][2] = p5;
    assign w_row_in[2][0] = p6;
    assign w_row_in[2][1] = p7;
    assign w_row_in[2][2] = p8;

    for (genvar g_r = 0; g_r < 3; g_r++) begin : g_row
        calculate_median_9_sort3 #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_row_sort (
            .i_a   (w_row_in[g_r][0]),
            .i_b   (w_row_in[g_r][1]),
            .i_c   (w_row_in[g_r][2]),
            .o_lo  (w_row_lo[g_r]),
            .o_mid (w_row_mid[g_r]),
            .o_hi  (w_row_hi[g_r])
        );
    end : g_row

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                r_row_lo[i]  <= '0;
                r_row_mid[i] <= '0;
                r_row_hi[i]  <= '0;
            end else begin
                r_row_lo[i]  <= w_row_lo[i];
                r_row_mid[i] <= w_row_mid[i];
                r_row_hi[i]  <= w_row_hi[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: column reduction. The largest row-minimum, the median of
    // row-medians and the smallest row-maximum bracket the true median;
    // only one output of each sorter is needed.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_c;
    logic [DATA_WIDTH-1:0] w_lo_unused_lo;
    logic [DATA_WIDTH-1:0] w_lo_unused_mid;
    logic [DATA_WIDTH-1:0] w_mid_unused_lo;
    logic [DATA_WIDTH-1:0] w_mid_unused_hi;
    logic [DATA_WIDTH-1:0] w_hi_unused_mid;
    logic [DATA_WIDTH-1:0] w_hi_unused_hi;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_c;

    calculate_median_9_sort3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sort_lo (
        .i_a   (r_row_lo[0]),
        .i_b   (r_row_lo[1]),
        .i_c   (r_row_lo[2]),
        .o_lo  (w_lo_unused_lo),
        .o_mid (w_lo_unused_mid),
        .o_hi  (w_a)
    );

    calculate_median_9_sort3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sort_mid (
        .i_a   (r_row_mid[0]),
        .i_b   (r_row_mid[1]),
        .i_c   (r_row_mid[2]),
        .o_lo  (w_mid_unused_lo),
        .o_mid (w_b),
        .o_hi  (w_mid_unused_hi)
    );

    calculate_median_9_sort3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sort_hi (
        .i_a   (r_row_hi[0]),
        .i_b   (r_row_hi[1]),
        .i_c   (r_row_hi[2]),
        .o_lo  (w_c),
        .o_mid (w_hi_unused_mid),
        .o_hi  (w_hi_unused_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            r_a <= w_a;
            r_b <= w_b;
            r_c <= w_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final median of the three candidates
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_med;
    logic [DATA_WIDTH-1:0] w_fin_unused_lo;
    logic [DATA_WIDTH-1:0] w_fin_unused_hi;

    calculate_median_9_sort3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sort_final (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_c   (r_c),
        .o_lo  (w_fin_unused_lo),
        .o_mid (w_med),
        .o_hi  (w_fin_unused_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            median <= '0;
        end else begin
            median <= w_med;
        end
    end

endmodule : calculate_median_9
`default_nettype wire

// File: tb/tb_calculate_median_9.sv
`default_nettype none
// ============================================================================
// Module   : tb_calculate_median_9
// Purpose  : Self-checking bench for calculate_median_9. Each applied window
//            pushes its expected median onto a queue; once the queue holds
//            LATENCY entries the oldest is popped and compared with median
//            after the edge. A reset edge flushes the queue and refills it
//            with zeros for the cleared pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculate_median_9;
    import calculate_median_9_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    typedef logic [DW-1:0] pix_t;

    typedef struct {
        string name;
        pix_t  p [9];
        pix_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pix_t p0 = '0, p1 = '0, p2 = '0, p3 = '0, p4 = '0;
    pix_t p5 = '0, p6 = '0, p7 = '0, p8 = '0;
    pix_t median;

    int tests_run    = 0;
    int tests_failed = 0;

    pix_t  exp_q  [$];
    string name_q [$];

    calculate_median_9 #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p0     (p0),
        .p1     (p1),
        .p2     (p2),
        .p3     (p3),
        .p4     (p4),
        .p5     (p5),
        .p6     (p6),
        .p7     (p7),
        .p8     (p8),
        .median (median)
    );

    always #5 clk = ~clk;

    // Reference: fifth smallest by full sort.
    function automatic pix_t ref_median(input pix_t w [9]);
        pix_t s [9];
        pix_t t;
        for (int i = 0; i < 9; i++) s[i] = w[i];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
        return s[4];
    endfunction

    // Drive one window (or a reset cycle) for one clock, then check the
    // median that leaves the pipeline on that edge.
    task automatic apply(input pix_t w [9], input logic r, input pix_t e, input string nm);
        pix_t  x;
        string xn;
        @(negedge clk);
        rst = r;
        p0 = w[0]; p1 = w[1]; p2 = w[2];
        p3 = w[3]; p4 = w[4]; p5 = w[5];
        p6 = w[6]; p7 = w[7]; p8 = w[8];
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            name_q.delete();
            for (int i = 0; i < LATENCY; i++) begin
                exp_q.push_back('0);
                name_q.push_back({nm, "_reset"});
            end
        end else begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        if (exp_q.size() >= LATENCY) begin
            x  = exp_q.pop_front();
            xn = name_q.pop_front();
            tests_run++;
            if (median !== x) begin
                tests_failed++;
                $display("FAIL %s: median=%0d expected=%0d", xn, median, x);
            end
        end
    endtask

    vec_t vecs [$];
    pix_t win  [9];
    pix_t zero_w [9];
    int   perms [6][3];
    pix_t rows  [3][3];

    initial begin
        vec_t v;

        for (int i = 0; i < 9; i++) zero_w[i] = '0;

        // Directed vectors with spec-given expected medians.
        v.name = "ordered";    v.p = '{10, 20, 30, 40, 50, 60, 70, 80, 90};     v.exp = 50;  vecs.push_back(v);
        v.name = "shuffled";   v.p = '{90, 10, 70, 30, 50, 80, 20, 60, 40};     v.exp = 50;  vecs.push_back(v);
        v.name = "all0";       v.p = '{0, 0, 0, 0, 0, 0, 0, 0, 0};             v.exp = 0;   vecs.push_back(v);
        v.name = "all255";     v.p = '{255, 255, 255, 255, 255, 255, 255, 255, 255}; v.exp = 255; vecs.push_back(v);
        v.name = "five255";    v.p = '{255, 0, 255, 0, 255, 0, 255, 0, 255};   v.exp = 255; vecs.push_back(v);
        v.name = "four255";    v.p = '{0, 255, 0, 255, 0, 255, 0, 255, 0};     v.exp = 0;   vecs.push_back(v);
        v.name = "dups7";      v.p = '{7, 7, 7, 3, 3, 9, 9, 9, 1};             v.exp = 7;   vecs.push_back(v);
        v.name = "five255_r0"; v.p = '{0, 0, 0, 0, 255, 255, 255, 255, 255};   v.exp = 255; vecs.push_back(v);
        v.name = "four255_r2"; v.p = '{255, 255, 255, 255, 0, 0, 0, 0, 0};     v.exp = 0;   vecs.push_back(v);

        perms = '{'{0, 1, 2}, '{0, 2, 1}, '{1, 0, 2}, '{1, 2, 0}, '{2, 0, 1}, '{2, 1, 0}};
        rows  = '{'{90, 10, 70}, '{30, 50, 80}, '{20, 60, 40}};

        // Reset state: median must read 0 at the reset edges.
        apply(zero_w, 1'b1, '0, "init");
        apply(zero_w, 1'b1, '0, "init");

        // Table vectors streamed back-to-back.
        foreach (vecs[k]) apply(vecs[k].p, 1'b0, vecs[k].exp, vecs[k].name);

        // Every row permutation (and within-row rotation) of the shuffled window.
        for (int pi = 0; pi < 6; pi++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r*3 + c] = rows[perms[pi][r]][(c + pi) % 3];
            apply(win, 1'b0, 8'd50, $sformatf("rowperm%0d", pi));
        end

        // Ordered input held steady: median stays 50 every clock.
        v = vecs[0];
        for (int i = 0; i < 6; i++) apply(v.p, 1'b0, 8'd50, "hold_ordered");

        // 20 consecutive random windows, no bubbles.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 9; i++) win[i] = pix_t'($urandom_range(0, 255));
            apply(win, 1'b0, ref_median(win), $sformatf("stream%0d", n));
        end

        // Reset for one clock mid-stream, then fresh windows.
        apply(vecs[1].p, 1'b1, '0, "midrst");
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 9; i++) win[i] = pix_t'($urandom_range(1, 255));
            apply(win, 1'b0, ref_median(win), $sformatf("postrst%0d", n));
        end

        // Bulk random, alternating full-range and narrow-range (tie-heavy) windows.
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 9; i++)
                win[i] = (n % 2 == 0) ? pix_t'($urandom_range(0, 255))
                                      : pix_t'($urandom_range(0, 3) * 85);
            apply(win, 1'b0, ref_median(win), $sformatf("rand%0d", n));
        end

        // Drain the pipeline so the last windows are checked too.
        for (int n = 0; n < LATENCY - 1; n++) apply(zero_w, 1'b0, '0, "drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_calculate_median_9
`default_nettype wire
